// File: rtl/calc1_top.sv
// Four-port integer calculator core: per-port command capture, a shared add/sub
// unit and a shared shifter behind fixed-priority arbitration, one-cycle responses.
module calc1_top (
   input  logic        c_clk,
   input  logic [1:7]  reset,
   input  logic [0:3]  req1_cmd_in,
   input  logic [0:31] req1_data_in,
   input  logic [0:3]  req2_cmd_in,
   input  logic [0:31] req2_data_in,
   input  logic [0:3]  req3_cmd_in,
   input  logic [0:31] req3_data_in,
   input  logic [0:3]  req4_cmd_in,
   input  logic [0:31] req4_data_in,
   output logic [0:1]  out_resp1,
   output logic [0:31] out_data1,
   output logic [0:1]  out_resp2,
   output logic [0:31] out_data2,
   output logic [0:1]  out_resp3,
   output logic [0:31] out_data3,
   output logic [0:1]  out_resp4,
   output logic [0:31] out_data4,
   input  logic [0:3]  error_found,
   input  logic        scan_in,
   output logic        scan_out,
   input  logic        a_clk,
   input  logic        b_clk
);

   typedef enum logic [1:0] {S_IDLE, S_OP2, S_READY} port_state_t;

   port_state_t state_q [4];
   logic [3:0]  cmd_q   [4];
   logic [31:0] op1_q   [4];
   logic [31:0] op2_q   [4];
   logic [1:0]  resp_q  [4];
   logic [31:0] data_q  [4];

   logic [3:0]  cmd_in  [4];
   logic [31:0] data_in [4];

   logic [3:0]  as_grant, sh_grant;
   logic [1:0]  as_sel, sh_sel;
   logic [31:0] as_a, as_b, as_res, sh_a, sh_res;
   logic [32:0] as_sum;
   logic [4:0]  sh_amt;
   logic        as_sub, as_ovf;

   logic        unused;
   assign unused   = ^{error_found, scan_in, a_clk, b_clk};
   assign scan_out = 1'b0;

   assign cmd_in[0] = req1_cmd_in;   assign data_in[0] = req1_data_in;
   assign cmd_in[1] = req2_cmd_in;   assign data_in[1] = req2_data_in;
   assign cmd_in[2] = req3_cmd_in;   assign data_in[2] = req3_data_in;
   assign cmd_in[3] = req4_cmd_in;   assign data_in[3] = req4_data_in;

   assign out_resp1 = resp_q[0];     assign out_data1 = data_q[0];
   assign out_resp2 = resp_q[1];     assign out_data2 = data_q[1];
   assign out_resp3 = resp_q[2];     assign out_data3 = data_q[2];
   assign out_resp4 = resp_q[3];     assign out_data4 = data_q[3];

   function automatic logic is_arith(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2);
   endfunction

   function automatic logic is_shift(input logic [3:0] c);
      return (c == 4'd5) || (c == 4'd6);
   endfunction

   // Lowest-numbered ready port wins each unit; losers stay READY and retry.
   always_comb begin
      as_grant = '0;
      sh_grant = '0;
      as_sel   = '0;
      sh_sel   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (state_q[i] == S_READY && is_arith(cmd_q[i]) && as_grant == '0) begin
            as_grant[i] = 1'b1;
            as_sel      = 2'(i);
         end
         if (state_q[i] == S_READY && is_shift(cmd_q[i]) && sh_grant == '0) begin
            sh_grant[i] = 1'b1;
            sh_sel      = 2'(i);
         end
      end
   end

   always_comb begin
      as_a   = op1_q[as_sel];
      as_b   = op2_q[as_sel];
      as_sub = (cmd_q[as_sel] == 4'd2);
      as_sum = {1'b0, as_a} + {1'b0, as_b};
      as_ovf = as_sub ? (as_b > as_a) : as_sum[32];
      as_res = as_ovf ? '0 : (as_sub ? as_a - as_b : as_sum[31:0]);
   end

   always_comb begin
      sh_a   = op1_q[sh_sel];
      sh_amt = op2_q[sh_sel][4:0];
      sh_res = (cmd_q[sh_sel] == 4'd5) ? (sh_a << sh_amt) : (sh_a >> sh_amt);
   end

   always_ff @(posedge c_clk) begin
      if (|reset) begin
         for (int unsigned i = 0; i < 4; i++) begin
            state_q[i] <= S_IDLE;
            cmd_q[i]   <= '0;
            op1_q[i]   <= '0;
            op2_q[i]   <= '0;
            resp_q[i]  <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            resp_q[i] <= '0;
            data_q[i] <= '0;
            case (state_q[i])
               S_IDLE: begin
                  if (cmd_in[i] != '0) begin
                     cmd_q[i]   <= cmd_in[i];
                     op1_q[i]   <= data_in[i];
                     state_q[i] <= S_OP2;
                  end
               end
               S_OP2: begin
                  op2_q[i]   <= data_in[i];
                  state_q[i] <= S_READY;
               end
               S_READY: begin
                  if (as_grant[i]) begin
                     resp_q[i]  <= as_ovf ? 2'd2 : 2'd1;
                     data_q[i]  <= as_res;
                     state_q[i] <= S_IDLE;
                  end else if (sh_grant[i]) begin
                     resp_q[i]  <= 2'd1;
                     data_q[i]  <= sh_res;
                     state_q[i] <= S_IDLE;
                  end else if (!is_arith(cmd_q[i]) && !is_shift(cmd_q[i])) begin
                     resp_q[i]  <= 2'd2;
                     state_q[i] <= S_IDLE;
                  end
               end
               default: state_q[i] <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calc1_top.sv
// Bench for calc1_top: directed vector table, hand sequences for reset/contention,
// and randomized multi-port batches checked against a timing/arith reference model.
module tb_calc1_top;

   logic        c_clk = 1'b0;
   logic [1:7]  reset;
   logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
   logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
   logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
   logic [0:31] out_data1, out_data2, out_data3, out_data4;
   logic [0:3]  error_found;
   logic        scan_in, scan_out, a_clk, b_clk;

   int checks = 0;
   int errors = 0;

   typedef logic [3:0][3:0]  nib4_t;
   typedef logic [3:0][31:0] word4_t;
   typedef logic [3:0][1:0]  resp4_t;

   typedef struct {
      int          port;
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  r;
      logic [31:0] d;
   } vec_t;

   vec_t vecs [12];

   calc1_top dut (
      .c_clk(c_clk), .reset(reset),
      .req1_cmd_in(req1_cmd_in), .req1_data_in(req1_data_in),
      .req2_cmd_in(req2_cmd_in), .req2_data_in(req2_data_in),
      .req3_cmd_in(req3_cmd_in), .req3_data_in(req3_data_in),
      .req4_cmd_in(req4_cmd_in), .req4_data_in(req4_data_in),
      .out_resp1(out_resp1), .out_data1(out_data1),
      .out_resp2(out_resp2), .out_data2(out_data2),
      .out_resp3(out_resp3), .out_data3(out_data3),
      .out_resp4(out_resp4), .out_data4(out_data4),
      .error_found(error_found), .scan_in(scan_in), .scan_out(scan_out),
      .a_clk(a_clk), .b_clk(b_clk)
   );

   always #5 c_clk = ~c_clk;

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
      case (p)
         0: begin req1_cmd_in = c; req1_data_in = d; end
         1: begin req2_cmd_in = c; req2_data_in = d; end
         2: begin req3_cmd_in = c; req3_data_in = d; end
         default: begin req4_cmd_in = c; req4_data_in = d; end
      endcase
   endtask

   function automatic logic [33:0] get_out(input int p);
      case (p)
         0: return {out_resp1, out_data1};
         1: return {out_resp2, out_data2};
         2: return {out_resp3, out_data3};
         default: return {out_resp4, out_data4};
      endcase
   endfunction

   task automatic check(input string name, input int p, input logic [1:0] er, input logic [31:0] ed);
      logic [33:0] o;
      o = get_out(p);
      checks++;
      if (o !== {er, ed}) begin
         errors++;
         $display("FAIL %s port%0d: got resp=%0d data=%h, want resp=%0d data=%h",
                  name, p + 1, o[33:32], o[31:0], er, ed);
      end
   endtask

   task automatic check_all_idle(input string name);
      for (int p = 0; p < 4; p++) check(name, p, 2'd0, 32'h0);
   endtask

   // Issues one command per port in the same cycle, then checks every port for
   // seven cycles: expected response exactly at its cycle, zeros otherwise.
   task automatic run_batch(input string name, input nib4_t c, input word4_t a, input word4_t b,
                            input resp4_t er, input word4_t ed, input nib4_t et);
      for (int p = 0; p < 4; p++) set_port(p, c[p], a[p]);
      step();
      for (int p = 0; p < 4; p++) set_port(p, 4'd0, b[p]);
      step();
      for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'h0);
      for (int k = 3; k <= 9; k++) begin
         step();
         for (int p = 0; p < 4; p++) begin
            if (c[p] != 4'd0 && k == int'(et[p])) check(name, p, er[p], ed[p]);
            else check(name, p, 2'd0, 32'h0);
         end
      end
   endtask

   function automatic int op_class(input logic [3:0] c);
      if (c == 4'd1 || c == 4'd2) return 1;
      if (c == 4'd5 || c == 4'd6) return 2;
      return 0;
   endfunction

   // Reference: plain wide arithmetic for results; response cycle is 3 plus the
   // number of higher-priority ports competing for the same unit in the batch.
   function automatic void model(input nib4_t c, input word4_t a, input word4_t b,
                                 output resp4_t er, output word4_t ed, output nib4_t et);
      longint unsigned x, y, s;
      int n;
      for (int p = 0; p < 4; p++) begin
         x = longint'(a[p]);
         y = longint'(b[p]);
         er[p] = 2'd2;
         ed[p] = 32'h0;
         case (c[p])
            4'd1: begin
               s = x + y;
               if (s <= 64'hFFFF_FFFF) begin er[p] = 2'd1; ed[p] = s[31:0]; end
            end
            4'd2: if (y <= x) begin s = x - y; er[p] = 2'd1; ed[p] = s[31:0]; end
            4'd5: begin er[p] = 2'd1; ed[p] = a[p] << (b[p] % 32); end
            4'd6: begin er[p] = 2'd1; ed[p] = a[p] >> (b[p] % 32); end
            default: ;
         endcase
         n = 0;
         for (int q = 0; q < p; q++)
            if (c[q] != 4'd0 && op_class(c[q]) != 0 && op_class(c[q]) == op_class(c[p])) n++;
         et[p] = 4'(op_class(c[p]) == 0 ? 3 : 3 + n);
      end
   endfunction

   initial begin
      nib4_t  c, et;
      word4_t a, b, ed;
      resp4_t er;
      logic [3:0] pick [6];

      error_found = '0;
      scan_in = 1'b0;
      a_clk = 1'b0;
      b_clk = 1'b0;
      for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'h0);

      vecs[0]  = '{0, 4'd1, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0008};
      vecs[1]  = '{0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[2]  = '{1, 4'd2, 32'h0000_0010, 32'h0000_0004, 2'd1, 32'h0000_000C};
      vecs[3]  = '{1, 4'd2, 32'h0000_0004, 32'h0000_0010, 2'd2, 32'h0000_0000};
      vecs[4]  = '{2, 4'd5, 32'h0000_0001, 32'h0000_0023, 2'd1, 32'h0000_0008};
      vecs[5]  = '{3, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
      vecs[6]  = '{0, 4'hF, 32'h0000_0005, 32'h0000_0003, 2'd2, 32'h0000_0000};
      vecs[7]  = '{2, 4'd3, 32'h0000_0007, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[8]  = '{3, 4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
      vecs[9]  = '{1, 4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000};
      vecs[10] = '{2, 4'd5, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
      vecs[11] = '{3, 4'd6, 32'h0000_1234, 32'h0000_0020, 2'd1, 32'h0000_1234};

      // Reset for 3 cycles with a command present; nothing may come out of it.
      reset = 7'h7F;
      set_port(0, 4'd1, 32'h1);
      for (int k = 0; k < 3; k++) begin
         step();
         check_all_idle("reset");
      end
      set_port(0, 4'd0, 32'h0);
      reset = 7'h00;
      for (int k = 0; k < 20; k++) begin
         step();
         check_all_idle("idle_after_reset");
      end

      for (int i = 0; i < 12; i++) begin
         c = '0; a = '0; b = '0; er = '0; ed = '0; et = '0;
         c[vecs[i].port]  = vecs[i].cmd;
         a[vecs[i].port]  = vecs[i].a;
         b[vecs[i].port]  = vecs[i].b;
         er[vecs[i].port] = vecs[i].r;
         ed[vecs[i].port] = vecs[i].d;
         et[vecs[i].port] = 4'd3;
         run_batch($sformatf("vec%0d", i), c, a, b, er, ed, et);
      end

      // All four ports add in the same cycle: serialized by priority.
      for (int p = 0; p < 4; p++) begin
         c[p]  = 4'd1;
         a[p]  = 32'h100 * p + 32'h1;
         b[p]  = 32'h10;
         er[p] = 2'd1;
         ed[p] = 32'h100 * p + 32'h11;
         et[p] = 4'(3 + p);
      end
      run_batch("all4_add", c, a, b, er, ed, et);

      // Mixed units in one cycle: add/sub and shift chains proceed in parallel.
      c  = {4'd6, 4'd5, 4'd2, 4'd1};
      a  = {32'hF0, 32'h1, 32'h9, 32'h2};
      b  = {32'h4, 32'h4, 32'h3, 32'h2};
      er = {2'd1, 2'd1, 2'd1, 2'd1};
      ed = {32'hF, 32'h10, 32'h6, 32'h4};
      et = {4'd4, 4'd3, 4'd4, 4'd3};
      run_batch("mixed_units", c, a, b, er, ed, et);

      // A second command while the first response is still pending is dropped.
      set_port(0, 4'd1, 32'h5);
      step();
      set_port(0, 4'd0, 32'h3);
      step();
      set_port(0, 4'd1, 32'h100);
      step();
      check("busy_first", 0, 2'd1, 32'h8);
      set_port(0, 4'd0, 32'h200);
      for (int k = 4; k <= 9; k++) begin
         step();
         set_port(0, 4'd0, 32'h0);
         check("busy_dropped", 0, 2'd0, 32'h0);
      end

      // Reset in T+1 discards the in-flight add.
      set_port(0, 4'd1, 32'h7);
      step();
      set_port(0, 4'd0, 32'h1);
      reset = 7'h7F;
      step();
      reset = 7'h00;
      set_port(0, 4'd0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         step();
         check_all_idle("mid_op_reset");
      end

      // Command right after a reset deasserts is accepted.
      reset = 7'h7F;
      step();
      reset = 7'h00;
      c = '0; a = '0; b = '0;
      c[1] = 4'd1; a[1] = 32'h22; b[1] = 32'h11;
      model(c, a, b, er, ed, et);
      run_batch("post_reset_cmd", c, a, b, er, ed, et);

      pick[0] = 4'd0; pick[1] = 4'd1; pick[2] = 4'd2;
      pick[3] = 4'd5; pick[4] = 4'd6; pick[5] = 4'd9;
      for (int n = 0; n < 60; n++) begin
         for (int p = 0; p < 4; p++) begin
            c[p] = pick[$urandom_range(0, 5)];
            if (c[p] == 4'd9) c[p] = 4'($urandom_range(7, 15));
            a[p] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
            b[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
         end
         model(c, a, b, er, ed, et);
         run_batch($sformatf("rand%0d", n), c, a, b, er, ed, et);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc1_top.md
Name: calc1_top

Overview:
- Four-port integer calculator core.
- Each requester port issues a command with two 32-bit operands over two consecutive cycles. It later receives a 2-bit response code and a 32-bit result on its own output port.
- Two shared execution units serve all four ports through fixed-priority arbitration: an add/sub unit and a shift unit.
- Sits below the calc1 top-level wrapper. That wrapper ties off the scan/LSSD clocks and the fault-injection control.

Parameters:
- None. All widths are fixed.

Ports:
- c_clk  in  1  system clock; all state updates on rising edge.
- reset  in  7 ([1:7])  synchronous, active-high. Core is in reset on any cycle where any bit is 1; bench drives 7'b1111111.
- req1_cmd_in..req4_cmd_in  in  4 each ([0:3])  command per port; 0 = idle.
- req1_data_in..req4_data_in  in  32 each ([0:31], bit 0 = MSB)  operand 1 in command cycle, operand 2 in next cycle.
- out_resp1..out_resp4  out  2 each ([0:1])  0 none, 1 success, 2 overflow/underflow/invalid command, 3 reserved (never driven).
- out_data1..out_data4  out  32 each ([0:31])  result; valid only when matching out_resp is nonzero.
- error_found  in  4 ([0:3])  fault-injection control. 4'b0000 selects nominal, spec-compliant behaviour; other values are reserved.
- scan_in  in  1  scan chain input; unused functionally.
- scan_out  out  1  scan chain output; drives 0.
- a_clk, b_clk  in  1 each  LSSD scan clocks; held 0, ignored.

Behaviour:
- Commands: 1 add, 2 subtract, 5 shift left logical, 6 shift right logical. Any other nonzero code is invalid.
- Protocol: cycle T samples a nonzero cmd with operand 1. Cycle T+1 samples operand 2; cmd must be 0 in T+1.
- One outstanding command per port. A new command on a port with a pending response is ignored; no response is produced for it.
- Add: 33-bit unsigned sum. If the carry out is set, resp=2 and data=0; otherwise resp=1 and data = sum[31:0].
- Subtract: if op2 > op1 (unsigned), resp=2 and data=0; otherwise resp=1 and data = op1-op2.
- Shift left/right: amount = op2 bits [27:31] (low 5 bits, 0..31). Zero fill; resp=1 always.
- Invalid command: resp=2, data=0. Does not use an execution unit.
- Arbitration: each unit accepts at most one operation per cycle. Fixed priority port1 > port2 > port3 > port4; a losing port holds its operands and retries every cycle.
- Add/sub and shift operations from different ports may issue in the same cycle.
- Latency: uncontended response appears in cycle T+3. Each cycle lost in arbitration adds one cycle.
- Response duration: exactly one cycle. All other cycles have resp=0 and data=0.
- Ports are independent: each port's response appears only on its own out_resp/out_data.
- Reset: all out_resp=0, out_data=0, operand holding registers and pending flags cleared. Reset in any cycle, including mid-operation, discards in-flight commands with no response. The first command is accepted in the first cycle after reset deasserts.
- Bus ordering: [0:31] with bit 0 as MSB throughout; arithmetic treats values as unsigned.

Test Plan:
- Reset (reset=7'h7F for 3 cycles) -> all out_resp=0, out_data=0; an idle port stays 0 for 20 cycles after deassertion.
- Port1 add 0x00000005 + 0x00000003 -> resp1=1, data1=0x00000008 in cycle T+3. Then 0xFFFFFFFF + 0x00000001 -> resp1=2, data1=0.
- Port2 subtract 0x10 - 0x04 -> resp=1, data=0x0000000C. Then 0x04 - 0x10 -> resp=2, data=0.
- Port3 shift left 0x00000001 by 0x00000023 (amount 3) -> resp=1, data=0x00000008. Port4 shift right 0x80000000 by 31 -> resp=1, data=0x00000001.
- All four ports issue add in the same cycle T -> responses on ports 1, 2, 3, 4 in cycles T+3, T+4, T+5, T+6 respectively, each for one cycle with correct sums.
- Port1 cmd=4'hF -> resp1=2, data1=0.
- Mid-operation reset: port1 add, reset asserted at T+1 -> no response is ever issued for that command.
